// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest performance-event logger.
// The record layout (coreid, value, delta, cycle) is fixed here at the default widths.
// Blocks built with other widths pack the same fields in the same order.
package difftest_pkg;

    localparam int DEFAULT_COREID_W = 8;
    localparam int DEFAULT_VALUE_W  = 32;
    localparam int CYCLE_W          = 64;
    localparam int DROP_W           = 16;

    // One snapshot record as it travels to the log sink, head of the FIFO first field
    typedef struct packed {
        logic [DEFAULT_COREID_W-1:0] coreid;
        logic [DEFAULT_VALUE_W-1:0]  value;
        logic [DEFAULT_VALUE_W-1:0]  delta;
        logic [CYCLE_W-1:0]          cycle;
    } log_record_t;

    localparam int DEFAULT_REC_W = $bits(log_record_t);

    // Increment that sticks at all-ones instead of wrapping back to zero
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] cnt);
        return (cnt == {DROP_W{1'b1}}) ? cnt : cnt + DROP_W'(1);
    endfunction

endpackage

// File: rtl/difftest_log_fifo.sv
// Small synchronous record FIFO for the event logger.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
// A write while full is accepted only if a read frees the head slot on the same edge.
module difftest_log_fifo
    import difftest_pkg::*;
#(
    parameter int WIDTH = DEFAULT_REC_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head is forced to zero when nothing is queued so stale entries never leak out
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values and storage contents for this edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer and storage registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/difftest_log_event.sv
// Per-event performance counter logger for difftest builds.
// Every INTERVAL cycles, or on flush, it snapshots the event counter into a record
// {coreid, value, delta since last snapshot, cycle stamp} and queues it for the log sink.
// Records that find the queue full are dropped and counted; the delta baseline still moves.
module difftest_log_event
    import difftest_pkg::*;
#(
    parameter     NAME     = "event",
    parameter int COREID_W = DEFAULT_COREID_W,
    parameter int VALUE_W  = DEFAULT_VALUE_W,
    parameter int INTERVAL = 1024,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic [COREID_W-1:0] coreid,
    input  logic [VALUE_W-1:0]  value,
    input  logic                rst,
    input  logic                flush,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [COREID_W-1:0] log_coreid,
    output logic [VALUE_W-1:0]  log_value,
    output logic [VALUE_W-1:0]  log_delta,
    output logic [CYCLE_W-1:0]  log_cycle,
    output logic [DROP_W-1:0]   drop_cnt
);

    localparam int            REC_W     = COREID_W + 2 * VALUE_W + CYCLE_W;
    localparam int            IW        = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0] LAST_TICK = IW'(INTERVAL - 1);

    logic [CYCLE_W-1:0] cycle_q;
    logic [CYCLE_W-1:0] cycle_d;
    logic [IW-1:0]      interval_q;
    logic [IW-1:0]      interval_d;
    logic [VALUE_W-1:0] last_value_q;
    logic [VALUE_W-1:0] last_value_d;
    logic [DROP_W-1:0]  drop_cnt_q;
    logic [DROP_W-1:0]  drop_cnt_d;

    logic               snap;
    logic               pop;
    logic               push_ok;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [VALUE_W-1:0] snap_delta;
    logic [REC_W-1:0]   rec_wr;
    logic [REC_W-1:0]   rec_rd;

    assign snap       = (interval_q == LAST_TICK) || flush;
    assign pop        = log_valid && log_ready;
    assign push_ok    = snap && (!fifo_full || pop);
    assign drop       = snap && fifo_full && !pop;
    assign snap_delta = value - last_value_q;
    assign rec_wr     = {coreid, value, snap_delta, cycle_q};

    assign log_valid = !fifo_empty;
    assign {log_coreid, log_value, log_delta, log_cycle} = rec_rd;
    assign drop_cnt  = drop_cnt_q;

    // Free-running cycle stamp, snapshot cadence, delta baseline and drop tally
    always_comb begin
        cycle_d      = cycle_q + CYCLE_W'(1);
        interval_d   = snap ? '0 : interval_q + IW'(1);
        last_value_d = snap ? value : last_value_q;
        drop_cnt_d   = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    // State registers, all cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q      <= '0;
            interval_q   <= '0;
            last_value_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            cycle_q      <= cycle_d;
            interval_q   <= interval_d;
            last_value_q <= last_value_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    difftest_log_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_data (rec_wr),
        .rd_en   (pop),
        .rd_data (rec_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef ENABLE_LOG
    // Simulation trace of every record that makes it into the queue
    always @(posedge clk) begin
        if (!rst && push_ok) begin
            $display("[%0d] %s core=%0d value=%0d delta=%0d",
                     cycle_q, NAME, coreid, value, snap_delta);
        end
    end
`else
    logic unused_name;
    assign unused_name = ^NAME;
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Directed bench for difftest_log_event with INTERVAL=4, DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// the log outputs depend only on registered state, so this sees the post-edge values.
module tb_difftest_log_event;

    localparam logic [7:0] CORE = 8'h3C;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         log_ready;
    logic         log_valid;
    logic [7:0]   coreid;
    logic [7:0]   log_coreid;
    logic [31:0]  value;
    logic [31:0]  log_value;
    logic [31:0]  log_delta;
    logic [63:0]  log_cycle;
    logic [15:0]  drop_cnt;
    logic [135:0] got_rec;
    logic [135:0] exp_rec;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    assign got_rec = {log_coreid, log_value, log_delta, log_cycle};

    difftest_log_event #(
        .NAME     ("tb_event"),
        .COREID_W (8),
        .VALUE_W  (32),
        .INTERVAL (4),
        .DEPTH    (4)
    ) dut (
        .clk        (clk),
        .coreid     (coreid),
        .value      (value),
        .rst        (rst),
        .flush      (flush),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_coreid (log_coreid),
        .log_value  (log_value),
        .log_delta  (log_delta),
        .log_cycle  (log_cycle),
        .drop_cnt   (drop_cnt)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        log_ready = 1'b1;
        coreid    = CORE;
        value     = 32'd0;
        tick(2);
        n_checks++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0", log_valid);
        end
        n_checks++;
        if (got_rec !== 136'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_record: got %h expected 0", got_rec);
        end
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_drop: got %0d expected 0", drop_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_constant_value();
        apply_reset();
        value     = 32'd0;
        log_ready = 1'b1;
        tick(3);
        n_checks++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL const_early: got valid=%b expected 0", log_valid);
        end
        tick(1);
        exp_rec = {CORE, 32'd0, 32'd0, 64'd3};
        n_checks++;
        if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
            n_fail++;
            $display("[TB] FAIL const_first: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
        end
        tick(1);
        n_checks++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL const_popped: got valid=%b expected 0", log_valid);
        end
        tick(3);
        exp_rec = {CORE, 32'd0, 32'd0, 64'd7};
        n_checks++;
        if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
            n_fail++;
            $display("[TB] FAIL const_second: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
        end
    endtask

    task automatic test_increment();
        apply_reset();
        log_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            value = 32'(k);
            tick(1);
            if (k == 4 || k == 8) begin
                exp_rec = {CORE, 32'(k), 32'd4, 64'(k - 1)};
                n_checks++;
                if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                    n_fail++;
                    $display("[TB] FAIL incr_k%0d: got valid=%b rec=%h expected valid=1 rec=%h", k, log_valid, got_rec, exp_rec);
                end
            end
        end
    endtask

    task automatic test_wrap_delta();
        apply_reset();
        log_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            value = (k <= 4) ? 32'hFFFF_FFFE : 32'h0000_0001;
            tick(1);
            if (k == 4) begin
                exp_rec = {CORE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'd3};
                n_checks++;
                if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_first: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
                end
            end
            if (k == 8) begin
                exp_rec = {CORE, 32'h0000_0001, 32'd3, 64'd7};
                n_checks++;
                if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_delta: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        log_ready = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            value = 32'(k);
            if (k == 25) log_ready = 1'b1;
            tick(1);
            case (k)
                5, 24: begin
                    exp_rec = {CORE, 32'd4, 32'd4, 64'd3};
                    n_checks++;
                    if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                        n_fail++;
                        $display("[TB] FAIL bp_head_k%0d: got valid=%b rec=%h expected valid=1 rec=%h", k, log_valid, got_rec, exp_rec);
                    end
                end
                25, 26, 27: begin
                    exp_rec = {CORE, 32'(4 * (k - 23)), 32'd4, 64'(4 * (k - 23) - 1)};
                    n_checks++;
                    if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                        n_fail++;
                        $display("[TB] FAIL bp_drain_k%0d: got valid=%b rec=%h expected valid=1 rec=%h", k, log_valid, got_rec, exp_rec);
                    end
                end
                28: begin
                    exp_rec = {CORE, 32'd28, 32'd4, 64'd27};
                    n_checks++;
                    if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                        n_fail++;
                        $display("[TB] FAIL bp_after_drop: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
                    end
                end
                default: ;
            endcase
            if (k == 16 || k == 20 || k == 24) begin
                n_checks++;
                if (drop_cnt !== 16'((k - 16) / 4)) begin
                    n_fail++;
                    $display("[TB] FAIL bp_drop_k%0d: got %0d expected %0d", k, drop_cnt, (k - 16) / 4);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        log_ready = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            value     = 32'(k);
            log_ready = (k >= 20);
            tick(1);
            if (k == 20 || k == 23) begin
                exp_rec = (k == 20) ? {CORE, 32'd8, 32'd4, 64'd7} : {CORE, 32'd20, 32'd4, 64'd19};
                n_checks++;
                if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_rec_k%0d: got valid=%b rec=%h expected valid=1 rec=%h", k, log_valid, got_rec, exp_rec);
                end
                n_checks++;
                if (drop_cnt !== 16'd0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_drop_k%0d: got %0d expected 0", k, drop_cnt);
                end
            end
        end
    endtask

    task automatic test_flush();
        apply_reset();
        log_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            value = 32'(k);
            flush = (k == 6);
            tick(1);
            if (k == 4 || k == 6 || k == 10) begin
                exp_rec = (k == 4) ? {CORE, 32'd4, 32'd4, 64'd3} :
                          (k == 6) ? {CORE, 32'd6, 32'd2, 64'd5} :
                                     {CORE, 32'd10, 32'd4, 64'd9};
                n_checks++;
                if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
                    n_fail++;
                    $display("[TB] FAIL flush_rec_k%0d: got valid=%b rec=%h expected valid=1 rec=%h", k, log_valid, got_rec, exp_rec);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (log_valid !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL flush_restart: got valid=%b expected 0", log_valid);
                end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        log_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            value = 32'(k);
            tick(1);
        end
        n_checks++;
        if (log_valid !== 1'b1 || drop_cnt !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL mid_before: got valid=%b drop=%0d expected valid=1 drop=1", log_valid, drop_cnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_valid: got %b expected 0", log_valid);
        end
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_drop: got %0d expected 0", drop_cnt);
        end
        n_checks++;
        if (got_rec !== 136'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_record: got %h expected 0", got_rec);
        end
        value = 32'd100;
        apply_reset();
        log_ready = 1'b1;
        tick(3);
        n_checks++;
        if (log_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_early: got valid=%b expected 0", log_valid);
        end
        tick(1);
        exp_rec = {CORE, 32'd100, 32'd100, 64'd3};
        n_checks++;
        if (log_valid !== 1'b1 || got_rec !== exp_rec) begin
            n_fail++;
            $display("[TB] FAIL mid_first: got valid=%b rec=%h expected valid=1 rec=%h", log_valid, got_rec, exp_rec);
        end
        n_checks++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_drop_after: got %0d expected 0", drop_cnt);
        end
    endtask

    initial begin
        $display("[TB] difftest_log_event directed tests start");
        test_reset();
        test_constant_value();
        test_increment();
        test_wrap_delta();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
